// File: rtl/phase_sequencer_pkg.sv
// Shared definitions for the instruction-cycle sequencer and its decoder neighbours:
// state encodings, default widths and opcode field values.
package phase_sequencer_pkg;

    localparam int INSTR_W_DEF = 16;
    localparam int CNT_W_DEF   = 16;

    typedef enum logic [2:0] {
        S_HALT  = 3'd0,
        S_FETCH = 3'd1,
        S_EX1   = 3'd2,
        S_EX2   = 3'd3,
        S_EX3   = 3'd4
    } state_t;

    // Top two instruction bits select the operation class.
    localparam int          OP_MSB = 15;
    localparam int          OP_LSB = 14;
    localparam logic [1:0]  OP_LDA = 2'b00;
    localparam logic [1:0]  OP_LDN = 2'b01;
    localparam logic [1:0]  OP_LDI = 2'b10;

endpackage

// File: rtl/phase_sequencer.sv
// Fetch/exec phase controller: latches the ROM word into the IR and issues one-hot phase strobes.
// Latency: one cycle per phase, 2-4 phases per instruction; IR/halted/count are registered.
// Backpressure: mem_ready=0 freezes the current phase and blanks every strobe.
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               step,
    input  logic               mem_ready,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               extra,
    input  logic               extra2,
    output logic [INSTR_W-1:0] instr,
    output logic               fetch,
    output logic               exec1,
    output logic               exec2,
    output logic               exec3,
    output logic               halted,
    output logic [CNT_W-1:0]   instr_count
);

    state_t             state_q, state_d;
    logic               step_mode_q, step_mode_d;
    logic [INSTR_W-1:0] instr_q;
    logic [CNT_W-1:0]   count_q;
    logic               load_ir;
    logic               retire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_HALT;
            step_mode_q <= 1'b0;
            instr_q     <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            step_mode_q <= step_mode_d;
            if (load_ir) instr_q <= instr_in;
            if (retire)  count_q <= count_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        step_mode_d = step_mode_q;
        load_ir     = 1'b0;
        retire      = 1'b0;
        case (state_q)
            S_HALT: begin
                // HALT is not a memory phase, so it ignores mem_ready.
                if (run) begin
                    state_d     = S_FETCH;
                    step_mode_d = 1'b0;
                end else if (step) begin
                    state_d     = S_FETCH;
                    step_mode_d = 1'b1;
                end
            end
            S_FETCH: begin
                if (mem_ready) begin
                    load_ir = 1'b1;
                    state_d = S_EX1;
                end
            end
            S_EX1: begin
                if (mem_ready) begin
                    if (extra) state_d = S_EX2;
                    else       retire  = 1'b1;
                end
            end
            S_EX2: begin
                if (mem_ready) begin
                    if (extra2) state_d = S_EX3;
                    else        retire  = 1'b1;
                end
            end
            S_EX3: begin
                if (mem_ready) retire = 1'b1;
            end
            default: state_d = S_HALT;
        endcase

        if (retire) begin
            state_d     = (run && !step_mode_q) ? S_FETCH : S_HALT;
            step_mode_d = 1'b0;
        end
    end

    assign fetch       = (state_q == S_FETCH) && mem_ready;
    assign exec1       = (state_q == S_EX1)   && mem_ready;
    assign exec2       = (state_q == S_EX2)   && mem_ready;
    assign exec3       = (state_q == S_EX3)   && mem_ready;
    assign halted      = (state_q == S_HALT);
    assign instr       = instr_q;
    assign instr_count = count_q;

endmodule
